// File: rtl/rx_iq_intf_if.sv
// Bundles the RX I/Q sample, stream, capture and status signals of rx_iq_intf.
// With RX_IQ_INTF_TIMESTAMP_EN defined the bundle also carries capture_timestamp.
interface rx_iq_intf_if #(
  parameter int IQ_DATA_WIDTH   = 16,
  parameter int GAIN_WIDTH      = 10,
  parameter int FIFO_DEPTH_LOG2 = 9
);
  logic [2*IQ_DATA_WIDTH-1:0] rf_iq_pack;
  logic                       rf_iq_valid;
  logic [GAIN_WIDTH-1:0]      bb_gain;
  logic [2*IQ_DATA_WIDTH-1:0] rx_iq_pack;
  logic                       rx_iq_valid;
  logic                       rx_iq_ready;
  logic                       capture_mode;
  logic                       capture_trigger;
  logic [FIFO_DEPTH_LOG2:0]   capture_len;
  logic                       slv_reg_rden;
  logic [4:0]                 axi_araddr_core;
  logic [2*IQ_DATA_WIDTH-1:0] capture_iq_out;
  logic                       capture_done;
  logic                       overflow_clr;
  logic                       rx_iq_overflow;
  logic                       rx_iq_fifo_empty;
  logic [FIFO_DEPTH_LOG2:0]   data_count;
`ifdef RX_IQ_INTF_TIMESTAMP_EN
  logic [31:0]                capture_timestamp;
`endif

  modport slave (
    input  rf_iq_pack, rf_iq_valid, bb_gain, rx_iq_ready, capture_mode,
           capture_trigger, capture_len, slv_reg_rden, axi_araddr_core, overflow_clr,
`ifdef RX_IQ_INTF_TIMESTAMP_EN
    output capture_timestamp,
`endif
    output rx_iq_pack, rx_iq_valid, capture_iq_out, capture_done,
           rx_iq_overflow, rx_iq_fifo_empty, data_count
  );

  modport master (
    output rf_iq_pack, rf_iq_valid, bb_gain, rx_iq_ready, capture_mode,
           capture_trigger, capture_len, slv_reg_rden, axi_araddr_core, overflow_clr,
`ifdef RX_IQ_INTF_TIMESTAMP_EN
    input  capture_timestamp,
`endif
    input  rx_iq_pack, rx_iq_valid, capture_iq_out, capture_done,
           rx_iq_overflow, rx_iq_fifo_empty, data_count
  );
endinterface

// File: rtl/rx_iq_intf.sv
// RX I/Q interface: saturating gain stage, FWFT sample FIFO, stream drain or triggered burst capture.
// Optional macro RX_IQ_INTF_TIMESTAMP_EN adds a sample-count timestamp latched at capture start.
module rx_iq_intf #(
  parameter int IQ_DATA_WIDTH   = 16,
  parameter int GAIN_WIDTH      = 10,
  parameter int GAIN_SHIFT      = 7,
  parameter int FIFO_DEPTH_LOG2 = 9
) (
  input logic         clk,
  input logic         rstn,
  rx_iq_intf_if.slave iq
);
  localparam int W     = IQ_DATA_WIDTH;
  localparam int DW    = 2 * IQ_DATA_WIDTH;
  localparam int PW    = IQ_DATA_WIDTH + GAIN_WIDTH;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic signed [PW-1:0] SAT_MAX = {{(GAIN_WIDTH+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(GAIN_WIDTH+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  function automatic logic signed [W-1:0] gain_sat(input logic signed [W-1:0] x,
                                                    input logic signed [GAIN_WIDTH-1:0] g);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ge;
    logic signed [PW-1:0] p;
    xe = PW'(x);
    ge = PW'(g);
    p  = (xe * ge) >>> GAIN_SHIFT;
    if (p > SAT_MAX) begin
      gain_sat = SAT_MAX[W-1:0];
    end else if (p < SAT_MIN) begin
      gain_sat = SAT_MIN[W-1:0];
    end else begin
      gain_sat = p[W-1:0];
    end
  endfunction

  state_e                     state_q, state_d;
  logic signed [W-1:0]        gi_q, gq_q, gi_d, gq_d;
  logic                       gvld_q, trig_q, ovf_q, ovf_d;
  logic [CW-1:0]              count_q, count_d, cap_cnt_q, cap_cnt_d, cap_inc_s;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]              mem_q [DEPTH];
  logic                       flush_s, wr_req_s, rd_s, wr_s, ovf_set_s, cap_start_s;
  logic                       full_s, empty_s, trig_rise_s, stream_s;
  logic [DW-1:0]              head_s;

  // Gain and saturation of the incoming sample
  always_comb begin
    gi_d = gain_sat(iq.rf_iq_pack[W-1:0], iq.bb_gain);
    gq_d = gain_sat(iq.rf_iq_pack[DW-1:W], iq.bb_gain);
  end

  // Gain-stage pipeline register and trigger edge history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gi_q   <= {W{1'b0}};
      gq_q   <= {W{1'b0}};
      gvld_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      gi_q   <= gi_d;
      gq_q   <= gq_d;
      gvld_q <= iq.rf_iq_valid;
      trig_q <= iq.capture_trigger;
    end
  end

  assign full_s      = (count_q == FULL_CNT);
  assign empty_s     = (count_q == ZERO_CNT);
  assign trig_rise_s = iq.capture_trigger & ~trig_q;
  assign cap_inc_s   = cap_cnt_q + ONE_CNT;

  // Capture FSM next state plus FIFO write/read/flush requests
  always_comb begin
    state_d     = state_q;
    flush_s     = 1'b0;
    wr_req_s    = 1'b0;
    rd_s        = 1'b0;
    cap_start_s = 1'b0;
    cap_cnt_d   = cap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (iq.capture_mode) begin
          state_d = S_ARMED;
          flush_s = 1'b1;
        end else begin
          wr_req_s = gvld_q;
          rd_s     = ~empty_s & iq.rx_iq_ready;
        end
      end
      S_ARMED: begin
        if (!iq.capture_mode) begin
          state_d = S_IDLE;
          flush_s = 1'b1;
        end else if (trig_rise_s && (iq.capture_len != ZERO_CNT)) begin
          state_d     = S_CAPTURE;
          cap_start_s = 1'b1;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_CAPTURE: begin
        if (!iq.capture_mode) begin
          state_d = S_IDLE;
          flush_s = 1'b1;
        end else if (gvld_q) begin
          wr_req_s = 1'b1;
          // A full FIFO drops the sample (overflow) and closes the burst
          if (full_s) begin
            state_d = S_DONE;
          end else begin
            cap_cnt_d = cap_inc_s;
            if (cap_inc_s == iq.capture_len) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CAPTURE;
            end
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_DONE: begin
        if (!iq.capture_mode) begin
          state_d = S_IDLE;
          flush_s = 1'b1;
        end else begin
          rd_s = iq.slv_reg_rden & (iq.axi_araddr_core == 5'd2) & ~empty_s;
          if (empty_s || (rd_s && (count_q == ONE_CNT))) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        flush_s = 1'b1;
      end
    endcase
  end

  // FIFO occupancy and sticky overflow next state
  always_comb begin
    wr_s      = wr_req_s & (~full_s | rd_s);
    ovf_set_s = wr_req_s & full_s & ~rd_s;
    count_d   = count_q;
    if (flush_s) begin
      count_d = ZERO_CNT;
    end else begin
      case ({wr_s, rd_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (iq.overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FSM, FIFO pointer, occupancy, capture counter and overflow registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      count_q   <= ZERO_CNT;
      wr_ptr_q  <= {FIFO_DEPTH_LOG2{1'b0}};
      rd_ptr_q  <= {FIFO_DEPTH_LOG2{1'b0}};
      cap_cnt_q <= ZERO_CNT;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (flush_s) begin
        wr_ptr_q <= {FIFO_DEPTH_LOG2{1'b0}};
        rd_ptr_q <= {FIFO_DEPTH_LOG2{1'b0}};
      end else begin
        if (wr_s) wr_ptr_q <= wr_ptr_q + {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
        if (rd_s) rd_ptr_q <= rd_ptr_q + {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      if (cap_start_s) begin
        cap_cnt_q <= ZERO_CNT;
      end else begin
        cap_cnt_q <= cap_cnt_d;
      end
    end
  end

  // Sample storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= {gq_q, gi_q};
    end
  end

  assign head_s              = mem_q[rd_ptr_q];
  assign stream_s            = (state_q == S_IDLE) & ~iq.capture_mode;
  assign iq.rx_iq_valid      = stream_s & ~empty_s;
  assign iq.rx_iq_pack       = iq.rx_iq_valid ? head_s : {DW{1'b0}};
  assign iq.capture_iq_out   = empty_s ? {DW{1'b0}} : head_s;
  assign iq.capture_done     = (state_q == S_DONE);
  assign iq.rx_iq_overflow   = ovf_q;
  assign iq.rx_iq_fifo_empty = empty_s;
  assign iq.data_count       = count_q;

`ifdef RX_IQ_INTF_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_lat_q;

  // Free-running valid-sample counter, latched when a capture starts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_cnt_q <= 32'd0;
      ts_lat_q <= 32'd0;
    end else begin
      if (gvld_q) ts_cnt_q <= ts_cnt_q + 32'd1;
      if (cap_start_s) ts_lat_q <= ts_cnt_q;
    end
  end

  assign iq.capture_timestamp = ts_lat_q;
`endif
endmodule

// File: doc/rx_iq_intf.md
Name: rx_iq_intf

Overview:
- Receive-side counterpart of the TX I/Q interface: accepts ADC/RF I/Q samples, applies baseband gain with saturation, and buffers them in an internal FIFO.
- Normal mode: the FIFO drains to the RX core over a valid/ready stream.
- Capture mode: a trigger-armed FSM records a fixed-length burst that the ARM reads word-by-word through the AXI-lite slave register read path.

Parameters:
- IQ_DATA_WIDTH, 16, width of each of I and Q.
- GAIN_WIDTH, 10, signed gain width.
- GAIN_SHIFT, 7, right-shift applied after the gain multiply.
- FIFO_DEPTH_LOG2, 9, FIFO depth is 2^FIFO_DEPTH_LOG2 words (512).

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- rf_iq_pack  in  2*IQ_DATA_WIDTH  {Q[31:16], I[15:0]}, signed.
- rf_iq_valid  in  1  input sample strobe; no backpressure.
- bb_gain  in  GAIN_WIDTH  signed gain.
- rx_iq_pack  out  2*IQ_DATA_WIDTH  FIFO head to RX core.
- rx_iq_valid  out  1  head valid.
- rx_iq_ready  in  1  RX core accept.
- capture_mode  in  1  1 = capture mode, 0 = stream mode.
- capture_trigger  in  1  rising edge starts capture.
- capture_len  in  FIFO_DEPTH_LOG2+1  samples to capture (1..2^FIFO_DEPTH_LOG2).
- slv_reg_rden  in  1  AXI read strobe.
- axi_araddr_core  in  5  AXI word address.
- capture_iq_out  out  2*IQ_DATA_WIDTH  FIFO head for ARM read.
- capture_done  out  1  burst complete, data readable.
- overflow_clr  in  1  clears overflow.
- rx_iq_overflow  out  1  sticky overflow flag.
- rx_iq_fifo_empty  out  1  FIFO empty.
- data_count  out  FIFO_DEPTH_LOG2+1  FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, except rx_iq_fifo_empty=1. FSM in IDLE; FIFO pointers cleared.
- Gain stage, one register:
  - product = I*bb_gain (and Q*bb_gain), arithmetic shift right by GAIN_SHIFT.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - Registered valid = rf_iq_valid delayed one cycle.
- Latency: a sample presented at cycle n into an empty FIFO is written at edge n+1. It appears on rx_iq_pack with rx_iq_valid=1 at cycle n+2 (FWFT).
- FIFO write, full condition:
  - When full, the incoming sample is dropped, rx_iq_overflow is set, and FIFO contents are unchanged.
  - overflow_clr clears the flag. A simultaneous set wins.
- Simultaneous read and write on a full or empty FIFO:
  - Write to full with a read in the same cycle is accepted; count unchanged.
  - Read from empty is ignored.
- Stream mode (capture_mode=0):
  - rx_iq_valid = ~empty. Pop when rx_iq_valid & rx_iq_ready.
  - Head held stable while valid & ~ready.
  - capture_done=0; ARM reads do not pop.
- Capture FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> ARMED when capture_mode=1. On entry the FIFO is flushed (one cycle), and rx_iq_valid is forced 0 for the whole time capture_mode=1.
  - ARMED: gain-stage samples are discarded. A rising capture_trigger with capture_len != 0 -> CAPTURE, sample counter cleared. capture_len=0 leaves the FSM in ARMED.
  - CAPTURE: each registered-valid sample is written and counted. When the count equals capture_len -> DONE. A full FIFO during CAPTURE sets overflow and ends the capture (-> DONE).
  - DONE: capture_done=1. slv_reg_rden with axi_araddr_core==2 pops one word; capture_iq_out shows the head (0 when empty). When the FIFO becomes empty -> ARMED; capture_done drops the same cycle.
- capture_mode cleared in any state: FSM -> IDLE next cycle, FIFO flushed, capture_done=0.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: RX_IQ_INTF_TIMESTAMP_EN.
- With the macro:
  - Adds output capture_timestamp [31:0].
  - A free-running 32-bit counter of registered-valid samples wraps at 2^32.
  - Its value is latched on the ARMED->CAPTURE transition and held until the next capture start; reset value 0.
- Without the macro: the port and the counter do not exist.

Test Plan:
- Gain/saturation: bb_gain=128, I=1000, Q=-1000 -> rx_iq_pack={-1000,1000} at cycle n+2. bb_gain=511, I=30000 -> I out = 32767.
- Backpressure: 10 samples with rx_iq_ready=0 -> data_count=10, head stable. Ready high -> 10 pops in order, then empty=1.
- Overflow: 515 samples with ready=0 -> data_count=512, overflow=1, the first 512 retained. overflow_clr -> flag 0.
- Capture: capture_mode=1, capture_len=8, trigger edge, 20 samples -> capture_done=1 after the 8th. 8 ARM reads at addr 2 return samples 1..8; then FSM ARMED, done=0.
- Abort: capture_mode dropped mid-CAPTURE after 3 samples -> IDLE, FIFO empty, done=0. capture_len=0 trigger -> stays ARMED.
- Timestamp (macro on): 100 valid samples, then trigger -> capture_timestamp=100. Reset -> 0.
